core_dbg_apb_arb: RTL and testbench

//   APB master that shares the core-debug APB slave between two requesters: port 0 (JTAG DTM)
//   and port 1 (system host). Arbitrates round-robin, runs the APB SETUP/ACCESS sequence,

---
 rtl/core_dbg_pkg.sv | 6 +
 rtl/core_dbg_rr_arb2.sv | 21 ++
 rtl/core_dbg_apb_arb.sv | 163 ++++++++++++++++
 tb/tb_core_dbg_apb_arb.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/core_dbg_pkg.sv
// Shared core-debug APB definitions: requester count and the master FSM state type.
package core_dbg_pkg;
  localparam int NUM_RQ = 2;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} apb_mst_state_t;
endpackage

// File: rtl/core_dbg_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port named by rr_ptr.
module core_dbg_rr_arb2
  import core_dbg_pkg::*;
(
  input  logic [NUM_RQ-1:0] valid,
  input  logic              rr_ptr,
  output logic [NUM_RQ-1:0] gnt,
  output logic              gnt_idx,
  output logic              any
);

  always_comb begin
    gnt_idx = 1'b0;
    if (valid == 2'b11) gnt_idx = rr_ptr;
    else if (valid[1])  gnt_idx = 1'b1;
    any = |valid;
    gnt = 2'b00;
    if (any) gnt = gnt_idx ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/core_dbg_apb_arb.sv
// APB master sharing the core-debug slave between the JTAG DTM (port 0) and system host (port 1).
//   state  | meaning
//   IDLE   | bus idle, arbitrate and latch the winner's request
//   SETUP  | psel high, penable low, load timeout
//   ACCESS | psel+penable high, wait for pready or timeout
//   DONE   | bus released, rq_done/rq_err/rq_rdata presented, rr_ptr advanced
module core_dbg_apb_arb
  import core_dbg_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 255,
  parameter int TMO_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        rq_valid,
  input  logic [1:0]        rq_wr_rd,
  input  logic [ADDR_W-1:0] rq_addr0,
  input  logic [ADDR_W-1:0] rq_addr1,
  input  logic [DATA_W-1:0] rq_wdata0,
  input  logic [DATA_W-1:0] rq_wdata1,
  input  logic [3:0]        rq_strb0,
  input  logic [3:0]        rq_strb1,
  output logic [1:0]        rq_grant,
  output logic [1:0]        rq_done,
  output logic              rq_err,
  output logic [DATA_W-1:0] rq_rdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic [3:0]        pstrb,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  apb_mst_state_t    state, state_nxt;
  logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_nxt;
  logic              win_idx, win_idx_nxt;
  logic              rr_ptr, rr_ptr_nxt;
  logic [1:0]        grant_nxt, done_nxt;
  logic              err_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt;
  logic [3:0]        pstrb_nxt;

  logic [1:0]        arb_gnt;
  logic              arb_idx, arb_any;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [3:0]        sel_strb;

  core_dbg_rr_arb2 u_arb (
    .valid   (rq_valid),
    .rr_ptr  (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign sel_wr    = rq_wr_rd[arb_idx];
  assign sel_addr  = arb_idx ? rq_addr1  : rq_addr0;
  assign sel_wdata = arb_idx ? rq_wdata1 : rq_wdata0;
  assign sel_strb  = arb_idx ? rq_strb1  : rq_strb0;

  always_comb begin
    state_nxt   = state;
    tmo_cnt_nxt = tmo_cnt;
    win_idx_nxt = win_idx;
    rr_ptr_nxt  = rr_ptr;
    grant_nxt   = rq_grant;
    done_nxt    = 2'b00;
    err_nxt     = 1'b0;
    rdata_nxt   = '0;
    psel_nxt    = psel;
    penable_nxt = penable;
    pwrite_nxt  = pwrite;
    paddr_nxt   = paddr;
    pwdata_nxt  = pwdata;
    pstrb_nxt   = pstrb;

    case (state)
      IDLE: begin
        if (arb_any) begin
          state_nxt   = SETUP;
          win_idx_nxt = arb_idx;
          grant_nxt   = arb_gnt;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          pwrite_nxt  = sel_wr;
          paddr_nxt   = sel_addr;
          pwdata_nxt  = sel_wdata;
          pstrb_nxt   = sel_wr ? sel_strb : 4'h0;
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
        tmo_cnt_nxt = TMO_W'(TMO_CYC - 1);
      end
      ACCESS: begin
        // Terminal count reached on the TMO_CYC-th wait cycle aborts the transfer.
        if (pready || tmo_cnt == '0) begin
          state_nxt         = DONE;
          psel_nxt          = 1'b0;
          penable_nxt       = 1'b0;
          grant_nxt         = 2'b00;
          done_nxt[win_idx] = 1'b1;
          err_nxt           = ~pready;
          if (pready && !pwrite) rdata_nxt = prdata;
        end else begin
          tmo_cnt_nxt = tmo_cnt - 1'b1;
        end
      end
      DONE: begin
        state_nxt   = IDLE;
        rr_ptr_nxt  = ~win_idx;
        tmo_cnt_nxt = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tmo_cnt  <= '0;
      win_idx  <= 1'b0;
      rr_ptr   <= 1'b0;
      rq_grant <= 2'b00;
      rq_done  <= 2'b00;
      rq_err   <= 1'b0;
      rq_rdata <= '0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      pstrb    <= 4'h0;
    end else begin
      state    <= state_nxt;
      tmo_cnt  <= tmo_cnt_nxt;
      win_idx  <= win_idx_nxt;
      rr_ptr   <= rr_ptr_nxt;
      rq_grant <= grant_nxt;
      rq_done  <= done_nxt;
      rq_err   <= err_nxt;
      rq_rdata <= rdata_nxt;
      psel     <= psel_nxt;
      penable  <= penable_nxt;
      pwrite   <= pwrite_nxt;
      paddr    <= paddr_nxt;
      pwdata   <= pwdata_nxt;
      pstrb    <= pstrb_nxt;
    end
  end

endmodule

// File: tb/tb_core_dbg_apb_arb.sv
// Self-checking bench for core_dbg_apb_arb: directed transfers plus randomized traffic
// checked against a transaction-level model of arbitration, bus contents and completion.
module tb_core_dbg_apb_arb;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rq_valid, rq_wr_rd;
  logic [4:0]  rq_addr0, rq_addr1;
  logic [31:0] rq_wdata0, rq_wdata1;
  logic [3:0]  rq_strb0, rq_strb1;
  logic [1:0]  rq_grant, rq_done;
  logic        rq_err;
  logic [31:0] rq_rdata;
  logic        psel, penable, pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_ptr  = 0;
  logic [1:0] gnt_log[$];

  core_dbg_apb_arb #(.ADDR_W(5), .DATA_W(32), .TMO_CYC(TMO), .TMO_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rq_valid(rq_valid), .rq_wr_rd(rq_wr_rd),
    .rq_addr0(rq_addr0), .rq_addr1(rq_addr1),
    .rq_wdata0(rq_wdata0), .rq_wdata1(rq_wdata1),
    .rq_strb0(rq_strb0), .rq_strb1(rq_strb1),
    .rq_grant(rq_grant), .rq_done(rq_done), .rq_err(rq_err), .rq_rdata(rq_rdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transfer starting from IDLE; winner and results come from the model.
  task automatic run_xfer(input int waits, input logic [31:0] rd_val,
                          input bit scramble, input bit hold);
    int win;
    logic wr;
    logic [4:0] ea;
    logic [31:0] ed;
    logic [3:0] es;
    logic [1:0] eg;
    bit exp_err;
    if (rq_valid == 2'b11) win = exp_ptr;
    else win = rq_valid[1] ? 1 : 0;
    eg = 2'(2'b01 << win);
    wr = rq_wr_rd[win];
    ea = (win == 1) ? rq_addr1 : rq_addr0;
    ed = (win == 1) ? rq_wdata1 : rq_wdata0;
    es = wr ? ((win == 1) ? rq_strb1 : rq_strb0) : 4'h0;
    exp_err = (waits >= TMO);
    pready = 1'($urandom);
    prdata = rd_val;
    tick();
    gnt_log.push_back(rq_grant);
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_grant", rq_grant, eg);
    chk("setup_paddr", paddr, ea);
    chk("setup_pwrite", pwrite, wr);
    chk("setup_pwdata", pwdata, ed);
    chk("setup_pstrb", pstrb, es);
    chk("setup_done", rq_done, 0);
    if (scramble) begin
      rq_addr0 = 5'($urandom); rq_addr1 = 5'($urandom);
      rq_wdata0 = $urandom;   rq_wdata1 = $urandom;
      rq_strb0 = 4'($urandom); rq_strb1 = 4'($urandom);
      rq_wr_rd = 2'($urandom);
    end
    pready = 1'($urandom);
    tick();
    chk("access_psel", psel, 1);
    chk("access_penable", penable, 1);
    chk("access_paddr", paddr, ea);
    chk("access_pwdata", pwdata, ed);
    chk("access_pstrb", pstrb, es);
    chk("access_grant", rq_grant, eg);
    for (int j = 0; j < TMO; j++) begin
      pready = (j == waits);
      tick();
      if (j == waits || j == TMO - 1) break;
      chk("wait_active", {30'd0, psel, penable}, 32'h3);
      chk("wait_paddr", paddr, ea);
      chk("wait_pwrite", pwrite, wr);
      chk("wait_done", rq_done, 0);
    end
    pready = 1'($urandom);
    chk("done_psel", {30'd0, psel, penable}, 0);
    chk("done_grant", rq_grant, 0);
    chk("done_pulse", rq_done, eg);
    chk("done_err", rq_err, exp_err);
    chk("done_rdata", rq_rdata, (exp_err || wr) ? 32'h0 : rd_val);
    exp_ptr = 1 - win;
    if (!hold) rq_valid[win] = 1'b0;
    tick();
    chk("idle_done", rq_done, 0);
    chk("idle_psel", psel, 0);
    chk("idle_err", rq_err, 0);
    pready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rq_valid = 2'b00; rq_wr_rd = 2'b00;
    rq_addr0 = '0; rq_addr1 = '0; rq_wdata0 = '0; rq_wdata1 = '0;
    rq_strb0 = '0; rq_strb1 = '0;
    pready = 1'b0; prdata = '0;
    tick(); tick();
    chk("rst_ctrl", {29'd0, psel, penable, pwrite}, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pstrb", pstrb, 0);
    chk("rst_grant", rq_grant, 0);
    chk("rst_done", rq_done, 0);
    chk("rst_err", rq_err, 0);
    chk("rst_rdata", rq_rdata, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_quiet", psel, 0);

    // Port-0 zero-wait write.
    rq_valid = 2'b01; rq_wr_rd = 2'b01; rq_addr0 = 5'h03;
    rq_wdata0 = 32'hDEADBEEF; rq_strb0 = 4'hF;
    run_xfer(0, 32'hAAAA5555, 1'b0, 1'b0);

    // Port-1 read with three wait states.
    rq_valid = 2'b10; rq_wr_rd = 2'b00; rq_addr1 = 5'h10;
    rq_wdata1 = 32'h0BADF00D; rq_strb1 = 4'hA;
    run_xfer(3, 32'h12345678, 1'b0, 1'b0);
    chk("p1_read_data_tail", rq_rdata, 0);

    // Both ports valid continuously: grants must alternate starting at port 0.
    gnt_log.delete();
    rq_valid = 2'b11; rq_wr_rd = 2'b10;
    rq_addr0 = 5'h01; rq_addr1 = 5'h02; rq_wdata0 = 32'h1111; rq_wdata1 = 32'h2222;
    rq_strb0 = 4'h3; rq_strb1 = 4'hC;
    for (int k = 0; k < 4; k++) run_xfer(k % 2, $urandom, 1'b0, 1'b1);
    chk("rr_order", {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]}, 8'b01_10_01_10);

    // Hung slave: read aborted after TMO access cycles.
    rq_valid = 2'b01; rq_wr_rd = 2'b00; rq_addr0 = 5'h1F;
    run_xfer(10, 32'hFFFFFFFF, 1'b0, 1'b0);

    // Reset in ACCESS with port 1 winning; afterwards port 0 must be preferred again.
    rq_valid = 2'b11; rq_wr_rd = 2'b11;
    tick();
    chk("rst_mid_grant", rq_grant, 2'(2'b01 << exp_ptr));
    tick();
    pready = 1'b0;
    tick();
    chk("rst_mid_access", {30'd0, psel, penable}, 32'h3);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_bus", {30'd0, psel, penable}, 0);
    chk("rst_mid_done", rq_done, 0);
    chk("rst_mid_grant_clr", rq_grant, 0);
    rst_n = 1'b1;
    exp_ptr = 0;
    gnt_log.delete();
    run_xfer(1, $urandom, 1'b0, 1'b0);
    chk("rst_mid_next_port0", gnt_log[0], 2'b01);

    // Request inputs change mid-transfer; bus fields must not follow.
    rq_valid = 2'b01; rq_wr_rd = 2'b00; rq_addr0 = 5'h0C;
    run_xfer(2, 32'hCAFEF00D, 1'b1, 1'b0);

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      rq_valid = 2'($urandom_range(1, 3));
      rq_wr_rd = 2'($urandom);
      rq_addr0 = 5'($urandom); rq_addr1 = 5'($urandom);
      rq_wdata0 = $urandom;   rq_wdata1 = $urandom;
      rq_strb0 = 4'($urandom); rq_strb1 = 4'($urandom);
      run_xfer($urandom_range(0, 5), $urandom, 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
